// File: rtl/cache_controller.sv
// Direct-mapped, write-back / write-allocate cache controller.
// Each line holds valid, dirty, tag and data; misses go through WRITE_BACK and ALLOCATE.
module cache_controller #(
  parameter int NUM_BLOCKS      = 4,
  parameter int WORDS_PER_BLOCK = 4
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         read_write,
  input  logic                         if_lb,
  input  logic [9:0]                   address,
  input  logic [31:0]                  write_data,
  output logic                         hit_miss,
  output logic [31:0]                  read_data,
  output logic                         mem_req,
  output logic                         mem_read_write,
  output logic [9:0]                   mem_address,
  output logic [32*WORDS_PER_BLOCK-1:0] mem_write_data,
  input  logic [32*WORDS_PER_BLOCK-1:0] mem_read_data,
  input  logic                         mem_ready
);
  localparam int IDX_W  = $clog2(NUM_BLOCKS);
  localparam int WRD_W  = $clog2(WORDS_PER_BLOCK);
  localparam int OFF_W  = WRD_W + 2;
  localparam int TAG_W  = 10 - IDX_W - OFF_W;
  localparam int LINE_W = 32 * WORDS_PER_BLOCK;

  typedef enum logic [1:0] {COMPARE, WRITE_BACK, ALLOCATE} state_t;

  state_t                              state_q, state_d;
  logic [NUM_BLOCKS-1:0]               valid_q, dirty_q;
  logic [NUM_BLOCKS-1:0][TAG_W-1:0]    tag_q;
  logic [NUM_BLOCKS-1:0][LINE_W-1:0]   data_q;

  logic [TAG_W-1:0]  req_tag;
  logic [IDX_W-1:0]  idx;
  logic [WRD_W-1:0]  wsel;
  logic [1:0]        bsel;
  logic [LINE_W-1:0] line;
  logic [31:0]       word;
  logic [7:0]        lb_byte;
  logic              hit;

  assign req_tag = address[9 -: TAG_W];
  assign idx     = address[OFF_W +: IDX_W];
  assign wsel    = address[2 +: WRD_W];
  assign bsel    = address[1:0];
  assign line    = data_q[idx];
  assign word    = line[{wsel, 5'b0} +: 32];
  assign lb_byte = word[{bsel, 3'b0} +: 8];
  assign hit     = (state_q == COMPARE) && valid_q[idx] && (tag_q[idx] == req_tag);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= COMPARE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d        = state_q;
    hit_miss       = hit;
    read_data      = '0;
    mem_req        = 1'b0;
    mem_read_write = 1'b0;
    mem_address    = '0;
    mem_write_data = '0;
    if (hit && !read_write)
      read_data = if_lb ? {{24{lb_byte[7]}}, lb_byte} : word;
    case (state_q)
      COMPARE: begin
        if (!hit) state_d = (valid_q[idx] && dirty_q[idx]) ? WRITE_BACK : ALLOCATE;
      end
      WRITE_BACK: begin
        // Victim address is rebuilt from the stored tag, not the request tag.
        mem_req        = 1'b1;
        mem_read_write = 1'b1;
        mem_address    = {tag_q[idx], idx, {OFF_W{1'b0}}};
        mem_write_data = line;
        if (mem_ready) state_d = ALLOCATE;
      end
      ALLOCATE: begin
        mem_req     = 1'b1;
        mem_address = {req_tag, idx, {OFF_W{1'b0}}};
        if (mem_ready) state_d = COMPARE;
      end
      default: state_d = COMPARE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      valid_q <= '0;
      dirty_q <= '0;
      tag_q   <= '0;
      data_q  <= '0;
    end else begin
      if (hit && read_write) begin
        data_q[idx][{wsel, 5'b0} +: 32] <= write_data;
        dirty_q[idx]                    <= 1'b1;
      end
      if (state_q == ALLOCATE && mem_ready) begin
        data_q[idx]  <= mem_read_data;
        valid_q[idx] <= 1'b1;
        dirty_q[idx] <= 1'b0;
        tag_q[idx]   <= req_tag;
      end
    end
  end
endmodule

// File: tb/tb_cache_controller.sv
// Randomized bench for cache_controller: a line-level cache model plus a backing memory
// predicts hit/miss, write-back traffic and load results for every request.
module tb_cache_controller;
  logic         clock = 1'b0;
  logic         reset, read_write, if_lb, mem_ready;
  logic [9:0]   address, mem_address;
  logic [31:0]  write_data, read_data;
  logic         hit_miss, mem_req, mem_read_write;
  logic [127:0] mem_write_data, mem_read_data;

  cache_controller dut (
    .clock(clock), .reset(reset), .read_write(read_write), .if_lb(if_lb),
    .address(address), .write_data(write_data), .hit_miss(hit_miss),
    .read_data(read_data), .mem_req(mem_req), .mem_read_write(mem_read_write),
    .mem_address(mem_address), .mem_write_data(mem_write_data),
    .mem_read_data(mem_read_data), .mem_ready(mem_ready)
  );

  always #5 clock = ~clock;

  int n_chk = 0;
  int n_err = 0;

  logic         m_valid [4];
  logic         m_dirty [4];
  logic [3:0]   m_tag   [4];
  logic [127:0] m_data  [4];
  logic [127:0] mem     [64];

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 4; i++) begin
      m_valid[i] = 1'b0; m_dirty[i] = 1'b0; m_tag[i] = '0; m_data[i] = '0;
    end
  endtask

  task automatic apply_reset();
    reset = 1'b1; read_write = 1'b0; if_lb = 1'b0; address = '0;
    write_data = '0; mem_ready = 1'b0; mem_read_data = '0;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    model_clear();
    #1;
    chk("rst_hit", hit_miss, 0);
    chk("rst_rdata", read_data, 0);
    chk("rst_req", mem_req, 0);
    chk("rst_rw", mem_read_write, 0);
    chk("rst_maddr", mem_address, 0);
    chk("rst_mwdata", mem_write_data, 0);
  endtask

  // Memory side of one transaction; starts just after a negedge with the DUT already requesting.
  task automatic serve(input bit wr, input logic [9:0] exp_addr, input logic [127:0] exp_wd,
                       input int waits);
    int w;
    w = (waits < 0) ? int'($urandom_range(0, 3)) : waits;
    for (int i = 0; i <= w; i++) begin
      #1;
      chk(wr ? "wb_req" : "al_req", mem_req, 1);
      chk(wr ? "wb_rw" : "al_rw", mem_read_write, wr);
      chk(wr ? "wb_addr" : "al_addr", mem_address, exp_addr);
      if (wr) chk("wb_data", mem_write_data, exp_wd);
      chk("mem_hm", hit_miss, 0);
      if (i < w) @(negedge clock);
    end
    if (wr) mem[exp_addr[9:4]] = exp_wd;
    else    mem_read_data = mem[exp_addr[9:4]];
    mem_ready = 1'b1;
    @(negedge clock);
    mem_ready = 1'b0;
    mem_read_data = {4{$urandom}};
  endtask

  task automatic access(input bit rw, input bit lb, input logic [9:0] a, input logic [31:0] wd,
                        input int waits, output logic [31:0] rd);
    int idx, tg, w, b;
    bit hit;
    logic [31:0] word, exp;
    idx = int'(a[5:4]); tg = int'(a[9:6]); w = int'(a[3:2]); b = int'(a[1:0]);
    read_write = rw; if_lb = lb; address = a; write_data = wd;
    mem_ready = $urandom_range(0, 1);
    #1;
    hit = m_valid[idx] && (m_tag[idx] == 4'(tg));
    if (!hit) begin
      chk("miss_hm", hit_miss, 0);
      chk("miss_req", mem_req, 0);
      @(negedge clock);
      mem_ready = 1'b0;
      if (m_valid[idx] && m_dirty[idx])
        serve(1'b1, {m_tag[idx], 2'(idx), 4'b0}, m_data[idx], waits);
      serve(1'b0, {4'(tg), 2'(idx), 4'b0}, '0, waits);
      m_data[idx] = mem[{4'(tg), 2'(idx)}];
      m_valid[idx] = 1'b1; m_dirty[idx] = 1'b0; m_tag[idx] = 4'(tg);
      #1;
    end
    word = m_data[idx][w*32 +: 32];
    exp  = lb ? {{24{word[b*8+7]}}, word[b*8 +: 8]} : word;
    chk("hit_hm", hit_miss, 1);
    chk("hit_req", mem_req, 0);
    if (!rw) chk("rdata", read_data, exp);
    rd = read_data;
    if (rw) begin
      m_data[idx][w*32 +: 32] = wd;
      m_dirty[idx] = 1'b1;
    end
    @(negedge clock);
    mem_ready = 1'b0;
  endtask

  initial begin
    logic [31:0] rd;
    logic [9:0]  a;
    for (int i = 0; i < 64; i++) mem[i] = {$urandom, $urandom, $urandom, $urandom};
    apply_reset();

    // Clean allocate, then single-cycle hits on the filled line.
    access(1'b1, 1'b0, 10'h1A8, 32'h3AB, -1, rd);
    access(1'b0, 1'b0, 10'h1A8, '0, -1, rd);
    chk("dir_rd_3ab", rd, 32'h0000_03AB);

    // Dirty victim written back before the conflicting fill, then a clean miss back.
    access(1'b1, 1'b0, 10'h1A8, 32'h3AC, -1, rd);
    access(1'b0, 1'b0, 10'h128, '0, -1, rd);
    access(1'b0, 1'b0, 10'h1A8, '0, -1, rd);
    chk("dir_rd_3ac", rd, 32'h0000_03AC);

    // Sign-extended byte loads.
    access(1'b1, 1'b0, 10'h1A8, 32'h3AD, -1, rd);
    access(1'b0, 1'b1, 10'h1A9, '0, -1, rd);
    chk("dir_lb_pos", rd, 32'h0000_0003);
    access(1'b1, 1'b0, 10'h1A8, 32'h0000_80AD, -1, rd);
    access(1'b0, 1'b1, 10'h1A9, '0, -1, rd);
    chk("dir_lb_neg", rd, 32'hFFFF_FF80);

    // Long memory stall during allocate; write-back also stalls since the line is dirty.
    access(1'b0, 1'b0, 10'h2A4, '0, 5, rd);

    // Reset in the middle of a write-back drops the request at once.
    access(1'b1, 1'b0, 10'h1A8, 32'h1234_5678, -1, rd);
    read_write = 1'b0; if_lb = 1'b0; address = 10'h128;
    @(negedge clock);
    #1;
    chk("wb_pre_req", mem_req, 1);
    chk("wb_pre_rw", mem_read_write, 1);
    reset = 1'b1;
    #1;
    chk("rst_drop_req", mem_req, 0);
    chk("rst_drop_hm", hit_miss, 0);
    @(negedge clock);
    reset = 1'b0;
    model_clear();
    access(1'b0, 1'b0, 10'h128, '0, -1, rd);
    access(1'b0, 1'b0, 10'h1A8, '0, -1, rd);

    // Random traffic over a small tag range to mix hits, clean and dirty misses.
    for (int n = 0; n < 300; n++) begin
      a = {2'b00, 2'($urandom), 2'($urandom), 2'($urandom), 2'($urandom)};
      access($urandom_range(0, 1), $urandom_range(0, 1), a, $urandom, -1, rd);
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
